// File: rtl/circular_rotate_serial_if.sv
// circular_rotate_serial_if: request (up_*) and result (down_*) valid/ready channels of the serial rotator
interface circular_rotate_serial_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
);
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_amount;
  logic          up_dir;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;
  modport master (
    output up_valid, up_data, up_amount, up_dir, down_ready,
    input  up_ready, down_valid, down_data
  );
  modport slave (
    input  up_valid, up_data, up_amount, up_dir, down_ready,
    output up_ready, down_valid, down_data
  );
endinterface

// File: rtl/circular_rotate_serial.sv
// circular_rotate_serial: rotates a word one bit per clock by (amount mod N) in either direction
module circular_rotate_serial #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input logic               clk,
  input logic               rst,
  circular_rotate_serial_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROTATE = 2'd1;
  localparam logic [1:0] OUT    = 2'd2;
  logic [1:0]    state;
  logic [N-1:0]  data;
  logic [SW-1:0] cnt;
  logic [SW-1:0] k;
  logic [SW:0]   amt_x;
  logic [N-1:0]  rot;
  logic          dir;
  logic          dv;
  // amount is below 2N, so a single conditional subtract yields amount mod N
  always_comb begin
    amt_x = {1'b0, bus.up_amount};
    k     = amt_x >= (SW+1)'(N) ? SW'(amt_x - (SW+1)'(N)) : bus.up_amount;
    rot   = dir ? {data[N-2:0], data[N-1]} : {data[0], data[N-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      dv    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.up_valid) begin
          data  <= bus.up_data;
          dir   <= bus.up_dir;
          cnt   <= k;
          state <= k != '0 ? ROTATE : OUT;
          dv    <= k == '0;
        end
        ROTATE: begin
          data <= rot;
          cnt  <= cnt - 1'b1;
          if (cnt == SW'(1)) begin
            state <= OUT;
            dv    <= 1'b1;
          end
        end
        OUT: if (bus.down_ready) begin
          state <= IDLE;
          dv    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.up_ready   = state == IDLE && !rst;
  assign bus.down_valid = dv;
  assign bus.down_data  = data;
endmodule
